barrier_field: RTL

Parametrised multi-row barrier scroller for the cart game: holds a ROWS × COLS field of barrier bits, accepts a new top row through a ready/valid handshake, and shifts the whole field down one row per scroll tick. The scroll period is selected at runtime by the `level` input. The block detects collision between the bottom row and the cart, freezes on game-over or collision, and optionally counts barrier rows passed. It sits between the barrier generator (upstream) and the LED-matrix driver and cart logic (downstream), replacing the per-row shifter chain.

---
 rtl/barrier_field.sv | 58 +++++
 1 files changed

// File: rtl/barrier_field.sv
// barrier_field: ROWS x COLS barrier scroller with level-selected scroll period and sticky collision flag.
// Optional row-passed score counter enabled by defining BARRIER_SCORE_EN.
module barrier_field #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int BASE_PERIOD = 16,
  parameter int SCORE_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gg,
  input  logic [1:0]           level,
  input  logic [COLS-1:0]      cart,
  input  logic [COLS-1:0]      new_row,
  input  logic                 new_valid,
  output logic                 new_ready,
  output logic [ROWS*COLS-1:0] field,
  output logic                 hit,
  output logic [SCORE_W-1:0]   score
);
  localparam int CW = $clog2(BASE_PERIOD) + 1;
  logic [CW-1:0] cnt, period, shifted;
  logic frozen, tick;
  logic [COLS-1:0] bottom, top;
  assign frozen = gg | hit;
  assign tick = (cnt == '0) & ~frozen;
  assign new_ready = tick;
  assign bottom = field[(ROWS-1)*COLS +: COLS];
  assign top = new_valid ? new_row : '0;
  always_comb begin
    shifted = CW'(BASE_PERIOD) >> level;
    period = (shifted == '0) ? CW'(1) : shifted;
  end
  // hit samples the pre-shift bottom row, so a simultaneous tick still detects the overlap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      field <= '0;
      hit <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= period - CW'(1);
        field <= {field[(ROWS-1)*COLS-1:0], top};
      end else if (!frozen) begin
        cnt <= cnt - CW'(1);
      end
      if (!gg) hit <= hit | (|(bottom & cart));
    end
  end
`ifdef BARRIER_SCORE_EN
  always_ff @(posedge clk) begin
    if (reset) score <= '0;
    else if (tick && (|bottom) && (score != '1)) score <= score + SCORE_W'(1);
  end
`else
  assign score = '0;
`endif
endmodule
